// File: rtl/opsg_i2s_tx.sv
// rtl/opsg_i2s_tx.sv - Philips I2S serializer for the opsg stereo sample pair
module opsg_i2s_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        sample_req
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] sr;
  logic        tick;
  logic        fall_evt;
  logic [4:0]  bit_nxt;

  assign tick     = (div_cnt == DIV_LAST);
  assign fall_evt = tick & i2s_bclk;
  assign bit_nxt  = bit_cnt + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      bit_cnt    <= 5'd31;
      sr         <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b1;
      i2s_sdata  <= 1'b0;
      sample_req <= 1'b0;
    end else if (!enable) begin
      div_cnt    <= '0;
      bit_cnt    <= 5'd31;
      sr         <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b1;
      i2s_sdata  <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      sample_req <= 1'b0;
      if (tick) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      // All slot state moves only on the bclk high-to-low toggle; sdata lags sr by one slot.
      if (fall_evt) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= bit_nxt[4];
        i2s_sdata <= sr[31];
        if (bit_nxt == 5'd0) begin
          sr         <= {audio_left, audio_right};
          sample_req <= 1'b1;
        end else begin
          sr <= {sr[30:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_opsg_i2s_tx.sv
// tb/tb_opsg_i2s_tx.sv - scoreboard bench for opsg_i2s_tx at BCLK_DIV 4 and 1
module tb_opsg_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en0 = 1'b0;
  logic        en1 = 1'b0;
  logic [15:0] l0 = '0;
  logic [15:0] r0 = '0;
  logic [15:0] l1 = '0;
  logic [15:0] r1 = '0;
  logic        bclk0, lr0, sd0, sq0;
  logic        bclk1, lr1, sd1, sq1;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q [2][$];

  always #5 clk = ~clk;

  opsg_i2s_tx #(.BCLK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .enable(en0), .audio_left(l0), .audio_right(r0),
    .i2s_bclk(bclk0), .i2s_lrclk(lr0), .i2s_sdata(sd0), .sample_req(sq0)
  );

  opsg_i2s_tx #(.BCLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .enable(en1), .audio_left(l1), .audio_right(r1),
    .i2s_bclk(bclk1), .i2s_lrclk(lr1), .i2s_sdata(sd1), .sample_req(sq1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [15:0] pat_l(input int c);
    logic [31:0] v;
    v = c * 32'h0931;
    return v[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] pat_r(input int c);
    logic [31:0] v;
    v = c * 32'h1F05 + 32'h0F0F;
    return v[15:0];
  endfunction

  // Receiver model: deserializes each frame (slots 1..31 plus slot 0 of the next frame)
  for (genvar d = 0; d < 2; d++) begin : g_mon
    localparam int DIV = (d == 0) ? 4 : 1;
    wire bc = (d == 0) ? bclk0 : bclk1;
    wire lr = (d == 0) ? lr0 : lr1;
    wire sd = (d == 0) ? sd0 : sd1;
    wire sq = (d == 0) ? sq0 : sq1;
    wire en = (d == 0) ? en0 : en1;
    logic        prev = 1'b0;
    logic        active = 1'b0;
    int          cnt = 0;
    int          period = 0;
    int          nbits = 0;
    logic [31:0] rx = '0;
    logic [31:0] want;

    always @(negedge clk) begin
      if (rst || !en) begin
        active = 1'b0;
        cnt    = 0;
        prev   = bc;
      end else begin
        cnt++;
        if (active) period++;
        if (sq) chk($sformatf("d%0d_sreq_on_fall", d), {31'b0, prev & ~bc}, 32'd1);
        if (bc != prev) begin
          if (active) chk($sformatf("d%0d_half_period", d), cnt, DIV);
          cnt = 0;
        end
        if (prev && !bc) begin
          if (sq) begin
            chk($sformatf("d%0d_lrclk_slot0", d), {31'b0, lr}, 32'd0);
            if (active) begin
              chk($sformatf("d%0d_frame_period", d), period, 64 * DIV);
              chk($sformatf("d%0d_frame_len", d), nbits, 31);
              rx = {rx[30:0], sd};
              if (exp_q[d].size() > 0) begin
                want = exp_q[d].pop_front();
                chk($sformatf("d%0d_frame_word", d), rx, want);
              end else begin
                chk($sformatf("d%0d_unexpected_frame", d), rx, 32'hxxxxxxxx);
              end
            end
            active = 1'b1;
            nbits  = 0;
            period = 0;
            rx     = '0;
          end else if (active) begin
            rx = {rx[30:0], sd};
            nbits++;
            chk($sformatf("d%0d_lrclk_slot%0d", d, nbits), {31'b0, lr}, {31'b0, nbits >= 16});
          end
        end
        prev = bc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then A55A/3C01 at div 4 and 8000/0001 at div 1
    en0 = 1'b1; en1 = 1'b1;
    l0 = 16'hA55A; r0 = 16'h3C01;
    l1 = 16'h8000; r1 = 16'h0001;
    exp_q[0].push_back(32'hA55A3C01);
    exp_q[0].push_back(32'hA55A3C01);
    exp_q[1].push_back(32'h80000001);
    exp_q[1].push_back(32'h80000001);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bclk", {31'b0, bclk0}, 32'd0);
    chk("rst_lrclk", {31'b0, lr0}, 32'd1);
    chk("rst_sdata", {31'b0, sd0}, 32'd0);
    chk("rst_sreq", {31'b0, sq0}, 32'd0);
    chk("rst_bclk_d1", {31'b0, bclk1}, 32'd0);
    chk("rst_lrclk_d1", {31'b0, lr1}, 32'd1);
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) chk("d1_sreq_c1", {31'b0, sq1}, 32'd0);
      if (i == 2) chk("d1_sreq_c2", {31'b0, sq1}, 32'd1);
      if (i == 4) chk("d0_bclk_rise_c4", {31'b0, bclk0}, 32'd1);
      if (i == 7) chk("d0_sreq_c7", {31'b0, sq0}, 32'd0);
      if (i == 8) chk("d0_sreq_c8", {31'b0, sq0}, 32'd1);
      if (i == 9) chk("d0_sreq_c9", {31'b0, sq0}, 32'd0);
    end
    repeat (141) @(posedge clk);
    #1 en1 = 1'b0;
    repeat (380) @(posedge clk);
    #1 en0 = 1'b0;

    // Drop enable mid-frame at slot 9 while bclk is high
    l0 = 16'h00FF; r0 = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1 en0 = 1'b1;
    repeat (84) @(posedge clk);
    #1;
    chk("slot9_bclk", {31'b0, bclk0}, 32'd1);
    chk("slot9_lrclk", {31'b0, lr0}, 32'd0);
    chk("slot9_sdata", {31'b0, sd0}, 32'd1);
    en0 = 1'b0;
    @(posedge clk);
    #1;
    chk("stop_bclk", {31'b0, bclk0}, 32'd0);
    chk("stop_lrclk", {31'b0, lr0}, 32'd1);
    chk("stop_sdata", {31'b0, sd0}, 32'd0);
    chk("stop_sreq", {31'b0, sq0}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_lrclk", {31'b0, lr0}, 32'd1);
    chk("hold_bclk", {31'b0, bclk0}, 32'd0);

    // Re-enable with inputs changing every clk; only the sample_req-cycle pair counts
    @(posedge clk);
    #1 en0 = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (c == 7) chk("reen_sreq_c7", {31'b0, sq0}, 32'd0);
      if (c == 8) chk("reen_sreq_c8", {31'b0, sq0}, 32'd1);
      l0 = pat_l(c);
      r0 = pat_r(c);
      if (c == 7) exp_q[0].push_back({pat_l(c), pat_r(c)});
      @(posedge clk);
      #1;
    end
    en0 = 1'b0;

    // Asynchronous reset between edges mid-frame, then recovery
    l0 = 16'h7E81; r0 = 16'hC3A5;
    exp_q[0].push_back(32'h7E81C3A5);
    @(posedge clk);
    #1 en0 = 1'b1;
    repeat (44) @(posedge clk);
    #1;
    chk("pre_rst_bclk", {31'b0, bclk0}, 32'd1);
    chk("pre_rst_lrclk", {31'b0, lr0}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_bclk", {31'b0, bclk0}, 32'd0);
    chk("async_rst_lrclk", {31'b0, lr0}, 32'd1);
    chk("async_rst_sdata", {31'b0, sd0}, 32'd0);
    chk("async_rst_sreq", {31'b0, sq0}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 7) chk("rec_sreq_c7", {31'b0, sq0}, 32'd0);
      if (i == 8) chk("rec_sreq_c8", {31'b0, sq0}, 32'd1);
    end
    repeat (262) @(posedge clk);
    #1 en0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("d0_queue_drained", exp_q[0].size(), 32'd0);
    chk("d1_queue_drained", exp_q[1].size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opsg_i2s_tx.md
OPSG_I2S_TX -- requirements
Module: opsg_i2s_tx

Interface
REQ-001 Parameter: BCLK_DIV, default 4, clk cycles per bclk half-period; legal range 1..255.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: enable  input  1  run when high; synchronous stop-and-clear when low.
REQ-005 Port: audio_left  input  16  two's-complement left sample from opsg.
REQ-006 Port: audio_right  input  16  two's-complement right sample from opsg.
REQ-007 Port: i2s_bclk  output  1  bit clock, registered.
REQ-008 Port: i2s_lrclk  output  1  word select; 0 = left, 1 = right; registered.
REQ-009 Port: i2s_sdata  output  1  serial data, MSB first, Philips I2S format; registered.
REQ-010 Port: sample_req  output  1  one-clk pulse when a new sample pair is latched.

Function
REQ-011 div_cnt counts 0..BCLK_DIV-1; on the clk edge where div_cnt == BCLK_DIV-1, i2s_bclk toggles and div_cnt returns to 0.
REQ-012 bclk period = 2*BCLK_DIV clk; frame = 32 bclk periods = 64*BCLK_DIV clk.
REQ-013 Slot events (bit_cnt, lrclk, sdata, shift register, sample_req) occur only on the clk edge where i2s_bclk toggles 1->0 (falling-edge event); nothing changes on rising toggles except i2s_bclk.
REQ-014 bit_cnt (5 bits) increments on each falling-edge event and wraps 31->0.
REQ-015 i2s_lrclk = 0 while bit_cnt is 0..15 and 1 while bit_cnt is 16..31, updated in the same edge as bit_cnt.
REQ-016 On the falling-edge event entering slot 0: i2s_sdata <= sr[31]; sr <= {audio_left, audio_right}; sample_req = 1 for that single clk cycle.
REQ-017 On every other falling-edge event: i2s_sdata <= sr[31]; sr <= sr << 1 (zero fill).
REQ-018 Result: slot k carries frame bit k-1 of {L,R}; slot 1 = L[15], slot 16 = L[0], slot 17 = R[15], slot 0 of the next frame = R[0] (one-bclk I2S delay).
REQ-019 Both channels are latched on the same clk edge; changes of audio_left/right at any other time have no effect on the frame in progress.
REQ-020 sample_req is 0 at all times other than REQ-016.
REQ-021 enable low: on the next clk edge div_cnt = 0, bit_cnt = 31, sr = 0, i2s_bclk = 0, i2s_lrclk = 1, i2s_sdata = 0, sample_req = 0; state is held while low, including mid-frame (frame aborted, no partial word resumes).
REQ-022 enable rising: timing restarts as after reset; first bclk rise BCLK_DIV clk later, first falling-edge event (slot 0, sample_req) 2*BCLK_DIV clk after enable high.
REQ-023 BCLK_DIV = 1: bclk toggles every clk; all rules above still hold.

Reset
REQ-024 rst high asynchronously forces div_cnt = 0, bit_cnt = 31, sr = 0, i2s_bclk = 0, i2s_lrclk = 1, i2s_sdata = 0, sample_req = 0.
REQ-025 Reset asserted mid-frame aborts the frame immediately; after release, behaviour is identical to REQ-022 when enable is high.
REQ-026 No output is X or Z after reset.

Verification
REQ-027 Reset release, enable=1, BCLK_DIV=4, L=16'hA55A, R=16'h3C01 -> sample_req pulse 8 clk after release; lrclk low for 16 bclk; sdata over slots 1..32 = A55A then 3C01 MSB first; lrclk rises at the falling bclk carrying L[0].
REQ-028 Change L/R every clk during a frame -> serialized bits equal values present at the sample_req cycle only.
REQ-029 BCLK_DIV=1, L=16'h8000, R=16'h0001 -> bclk period 2 clk, frame 64 clk; sdata 1 at slot 1 and slot 0 of next frame only; sample_req every 64 clk.
REQ-030 Drop enable at bit_cnt=9 -> next clk: bclk=0, lrclk=1, sdata=0; re-enable -> new frame with fresh latch after 2*BCLK_DIV clk.
REQ-031 Assert rst asynchronously between clk edges mid-frame -> outputs reach reset values before next clk edge; recovery per REQ-025.
REQ-032 Connect to opsg with MAX_VOLUME=2048, ch1 at max volume -> deserialized left/right words equal audio_left/audio_right sampled at each sample_req.
